// File: rtl/btn_pkg.sv
// Shared types for the push-button conditioner: debounce FSM states and
// synchronizer depth.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchronizer, counter-based debounce FSM,
// registered level plus one-cycle press/release strobes.
// Optional auto-repeat of the press strobe while held: define BTN_REPEAT_EN.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_n,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time sanity check on the timing parameters.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("btn_channel: DEBOUNCE_CYCLES must be >= 2 and REPEAT_* >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  btn_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   rel_q, rel_d;
  logic                   p;

  // Shift the raw (active-low) input through the synchronizer.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_n};
  end

  assign p = ~sync_q[SYNC_STAGES-1];

`ifdef BTN_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_q, rep_d;
  logic              rep_fire;
  logic [HOLD_W-1:0] hold_lim;

  // Hold counter: first strobe after REPEAT_DELAY, then every REPEAT_PERIOD;
  // cleared whenever the channel is not staying in HELD.
  always_comb begin
    hold_lim = rep_q ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
    hold_d   = '0;
    rep_d    = 1'b0;
    rep_fire = 1'b0;
    if (state_q == HELD && p) begin
      if (hold_q == hold_lim) begin
        rep_fire = 1'b1;
        rep_d    = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
        rep_d  = rep_q;
      end
    end
  end

  // Hold counter state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  logic rep_fire;
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM: a change is accepted only after DEBOUNCE_CYCLES stable cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = rep_fire;
    rel_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (p) begin
          state_d = ARM_PRESS;
          cnt_d   = '0;
        end
      end
      ARM_PRESS: begin
        if (!p) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!p) begin
          state_d = ARM_RELEASE;
          cnt_d   = '0;
        end
      end
      ARM_RELEASE: begin
        if (p) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Channel state and registered outputs; sync flops reset to "unpressed".
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= '1;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Button conditioner top: fans the raw active-low buttons out to independent
// debounce channels and gathers level/press/release. Auto-repeat is enabled
// by defining BTN_REPEAT_EN.
module button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [N_BTN-1:0] Btn_n,
  output logic [N_BTN-1:0] Level,
  output logic [N_BTN-1:0] Press,
  output logic [N_BTN-1:0] Release
);

  btn_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_ch [N_BTN-1:0] (
    .Clk  (Clk),
    .Reset(Reset),
    .btn_n(Btn_n),
    .level(Level),
    .press(Press),
    .rel  (Release)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared every cycle against a run-length reference model.
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [NB-1:0] Btn_n;
  logic [NB-1:0] Level, Press, Release;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: input delay line, accepted level, length of the current
  // run of cycles disagreeing with the level, and age within a held period.
  bit          m_s1 [NB];
  bit          m_s2 [NB];
  bit          m_lvl[NB];
  int          m_run[NB];
  int          m_age[NB];
  logic [NB-1:0] e_level, e_press, e_rel;

  button_conditioner #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Btn_n(Btn_n),
    .Level(Level), .Press(Press), .Release(Release)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_mis++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NB; i++) begin
      m_s1[i] = 1'b1; m_s2[i] = 1'b1; m_lvl[i] = 1'b0;
      m_run[i] = 0;   m_age[i] = 0;
    end
    e_level = '0; e_press = '0; e_rel = '0;
  endtask

  // A level change is accepted once the pressed-state seen by the logic has
  // disagreed with the current level for DB+1 consecutive edges.
  task automatic m_edge();
    bit p;
    for (int i = 0; i < NB; i++) begin
      p = !m_s2[i];
      m_s2[i] = m_s1[i];
      m_s1[i] = Btn_n[i];
      e_press[i] = 1'b0;
      e_rel[i]   = 1'b0;
      if (p != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB + 1) begin
          m_lvl[i] = p;
          m_run[i] = 0;
          if (p) begin
            e_press[i] = 1'b1;
            m_age[i]   = 0;
          end else begin
            e_rel[i] = 1'b1;
          end
        end
      end else begin
        if (m_lvl[i]) begin
          if (m_run[i] > 0) m_age[i] = 0;
          else begin
            m_age[i]++;
`ifdef BTN_REPEAT_EN
            if (m_age[i] == RD || (m_age[i] > RD && (m_age[i] - RD) % RP == 0))
              e_press[i] = 1'b1;
`endif
          end
        end
        m_run[i] = 0;
      end
      e_level[i] = m_lvl[i];
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic tick(input string tag);
    @(posedge Clk);
    if (Reset) m_reset(); else m_edge();
    @(negedge Clk);
    chk({tag, ".level"},   Level,   e_level);
    chk({tag, ".press"},   Press,   e_press);
    chk({tag, ".release"}, Release, e_rel);
  endtask

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic async_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    m_reset();
    chk({tag, ".async_zero"}, Level | Press | Release, '0);
  endtask

  initial begin
    int npress;
    logic [NB-1:0] ch;
    Reset = 1'b1;
    Btn_n = '1;
    m_reset();
    repeat (3) tick("rst_hold");

    // Reset behaviour: all pressed through reset, accepted at edge 6
    Btn_n = 4'b0000;
    tick("rst_hold_low");
    Reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick("rst_release");
      chk("rst_release.press_k", Press, (k == 6) ? 4'b1111 : 4'b0000);
      chk("rst_release.level_k", Level, (k >= 6) ? 4'b1111 : 4'b0000);
    end
    async_reset("rst_async");
    tick("rst_async_hold");
    Btn_n = 4'b1111;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (4) tick("settle");

    // Clean press and release on channel 1
    Btn_n = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      tick("press1");
      if (k == 6) chk("press1.strobe", Press, 4'b0010);
    end
    Btn_n = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick("rel1");
      if (k == 6) chk("rel1.strobe", Release, 4'b0010);
    end
    chk("rel1.level_low", Level, 4'b0000);

    // Bounce rejection on channel 2, then the same glitches while held
    npress = 0;
    foreach (ch[i]) ch[i] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      Btn_n[2] = (k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1;
      tick("bounce_press");
      npress += int'(Press[2]);
    end
    chk_int("bounce_press.no_strobe", npress, 0);
    chk("bounce_press.level", Level, 4'b0000);
    Btn_n[2] = 1'b0;
    repeat (10) tick("hold2");
    npress = 0;
    for (int k = 0; k < 12; k++) begin
      Btn_n[2] = (k < 3 || (k >= 4 && k < 7)) ? 1'b1 : 1'b0;
      tick("bounce_rel");
      npress += int'(Release[2]);
    end
    chk_int("bounce_rel.no_strobe", npress, 0);
    chk("bounce_rel.level", Level, 4'b0100);
    Btn_n[2] = 1'b1;
    repeat (10) tick("rel2");

    // Reset in the middle of a debounce on channel 0
    Btn_n = 4'b1110;
    repeat (4) tick("mid_dbnc");
    async_reset("mid_dbnc_rst");
    tick("mid_dbnc_edge4");
    Reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick("post_rst");
      chk("post_rst.press_k", Press, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Channel 3 pressed and channel 0 released on the same edge
    Btn_n = 4'b0111;
    for (int k = 0; k < 9; k++) begin
      tick("simul");
      if (k == 6) begin
        chk("simul.press", Press, 4'b1000);
        chk("simul.release", Release, 4'b0001);
      end
    end
    Btn_n = 4'b1111;
    repeat (10) tick("simul_rel");

    // Long hold on channel 1: auto-repeat when enabled, single press otherwise
    npress = 0;
    Btn_n = 4'b1101;
    for (int k = 0; k < 30; k++) begin
      tick("hold1");
      npress += int'(Press[1]);
    end
    Btn_n = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick("hold1_rel");
      npress += int'(Press[1]);
    end
`ifdef BTN_REPEAT_EN
    chk_int("hold1.press_count", npress, 7);
`else
    chk_int("hold1.press_count", npress, 1);
`endif

    // Random activity with occasional asynchronous resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NB; i++)
        if ($urandom_range(0, 5) == 0) Btn_n[i] = ~Btn_n[i];
      if ($urandom_range(0, 199) == 0) begin
        async_reset("rand_rst");
        tick("rand_rst_hold");
        Reset = 1'b0;
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage that conditions the raw, active-low push buttons (Reset, LoadA, LoadB, Execute) before they reach the logic processor's control unit.
- Per button: synchronize, debounce with a counter-based FSM, then produce a clean active-high level plus single-cycle press and release strobes.
- Replaces bare synchronizers on button paths. The control unit consumes Level (or Press) instead of raw synchronized inputs.

Parameters:
- N_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable Clk cycles required to accept a change (10 ms at 50 MHz). Must be >= 2.
- REPEAT_DELAY, 25000000, cycles held before the first auto-repeat strobe. Used only with BTN_REPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat strobes. Used only with BTN_REPEAT_EN.

Ports:
- Clk      in   1      system clock
- Reset    in   1      asynchronous, active-high reset
- Btn_n    in   N_BTN  raw push-button inputs, active low, asynchronous to Clk
- Level    out  N_BTN  debounced button state, 1 = pressed
- Press    out  N_BTN  one-cycle strobe on accepted press (and on auto-repeat when enabled)
- Release  out  N_BTN  one-cycle strobe on accepted release

Behaviour:
- Channels are fully independent. Everything below is per channel.
- Reset (async, active-high):
  - sync flops reset to 1 (unpressed)
  - FSM to IDLE, counter to 0
  - Level, Press and Release all reset to 0
  - Reset mid-debounce discards the partial count; no strobe is emitted.
- Synchronizer:
  - Two flops on Btn_n. The FSM uses p = ~sync2.
  - Edge 0 is the first edge that samples the new raw level; p reflects it after edge 1.
- FSM states: IDLE, ARM_PRESS, HELD, ARM_RELEASE. All outputs are registered.
- IDLE (Level=0): if p=1, go to ARM_PRESS with cnt=0.
- ARM_PRESS (Level=0):
  - p=0: go to IDLE, cnt=0 (bounce rejected, no strobe).
  - p=1 and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - p=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, Level<=1, Press<=1 for exactly one cycle.
- HELD (Level=1): if p=0, go to ARM_RELEASE with cnt=0.
- ARM_RELEASE (Level=1):
  - p=1: go to HELD, cnt=0 (no strobe).
  - p=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, Level<=0, Release<=1 for one cycle.
  - otherwise cnt++.
- Latency: for a stable input, Press/Level rise on edge DEBOUNCE_CYCLES+2 after edge 0. Release/fall has the same latency.
- Pulses shorter than DEBOUNCE_CYCLES cycles never produce a strobe and never change Level.
- Press and Release are never asserted in the same cycle on one channel.
- Minimum spacing between Press and the following Release is DEBOUNCE_CYCLES+1 cycles.
- Counter width is $clog2(DEBOUNCE_CYCLES). It saturates at DEBOUNCE_CYCLES-1 and never wraps.
- Simultaneous events on different channels are handled independently in the same cycle.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined: HELD gains a hold counter.
  - First extra Press strobe comes REPEAT_DELAY cycles after entering HELD.
  - Further strobes follow every REPEAT_PERIOD cycles while in HELD.
  - Leaving HELD, or Reset, clears the hold counter.
  - Level is unaffected. Repeat strobes are one cycle wide, identical to a normal Press.
- Undefined: no hold counter is synthesized, and Press fires only once per accepted press.

Decomposition:
- Package btn_pkg:
  - enum btn_state_t {IDLE, ARM_PRESS, HELD, ARM_RELEASE}
  - localparam SYNC_STAGES = 2
- Sub-module btn_channel:
  - one synchronizer + FSM + counter(s)
  - carries the DEBOUNCE_CYCLES/REPEAT_* parameters
  - instantiated N_BTN times via an instance array.
- Top button_conditioner only fans out Btn_n and collects the outputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=4):
- Reset behaviour: assert Reset asynchronously with Btn_n=4'b0000 held -> Level=Press=Release=0 immediately. After deassert with Btn_n=4'b0000 held -> Level=4'b1111 and Press=4'b1111 for one cycle at edge 6.
- Clean press: Btn_n[1] low from edge 0 -> Press[1]=1 only in the cycle after edge 6, Level[1]=1 thereafter, other bits 0. Release high from edge 0' -> Release[1] one cycle after edge 6', Level[1]=0.
- Bounce rejection: Btn_n[2] pattern low 3 cycles / high 1 / low 3 / high -> no Press[2], Level[2] stays 0. Same glitches while held -> no Release[2].
- Reset mid-debounce: Btn_n[0] low, Reset pulsed at edge 4 -> no Press[0]. After Reset drops with input still low, Press[0] arrives exactly 6 edges after the first post-reset edge.
- Simultaneous channels: Btn_n[3] falls and Btn_n[0] rises (after being held) on the same edge -> Press[3] and Release[0] in the same cycle, 6 edges later.
- BTN_REPEAT_EN: hold Btn_n[1] low for 30 cycles -> Press[1] at the acceptance edge E, then at E+10, E+13, E+16, ... until release. Without the macro -> a single Press[1] only.
